elevator_sched: RTL and testbench
=================================

Name: elevator_sched

Overview:
- Single-car LOOK scheduler for the elevator datapath.
- Latches hall calls (upreq/downreq) and cab calls (carreq) into pending registers, and tracks the car's current floor and travel direction.
- Sequences motion and door timing, driving up/down/open strobes and the floor index to the floor display.
- Replaces ad-hoc request resolution with a timed, direction-aware controller.

Parameters:
- NUM_FLOORS, 10, number of floors (floor 0 = lobby).
- FLOOR_BITS, $clog2(NUM_FLOORS), width of floor index.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 6, clock cycles the door stays open per stop (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetN  input  1  synchronous reset, active-high (asserted = 1); one clock domain only.
- upreq  input  NUM_FLOORS  hall up-call buttons, level, one bit per floor.
- downreq  input  NUM_FLOORS  hall down-call buttons, level, one bit per floor.
- carreq  input  NUM_FLOORS  cab destination buttons, level, one bit per floor.
- floor  output  FLOOR_BITS  current car floor, registered.
- up  output  1  car moving up (asserted for the full travel between floors).
- down  output  1  car moving down.
- open  output  1  door open.
- dir_up  output  1  current/last travel direction (1 = up).
- up_pend  output  NUM_FLOORS  latched up-call lamps.
- down_pend  output  NUM_FLOORS  latched down-call lamps.
- car_pend  output  NUM_FLOORS  latched cab-call lamps.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: only clk/resetN sampled. On resetN=1 at an edge:
  - floor=0, dir_up=1, state=IDLE, timers=0.
  - up=down=open=busy=0; all pend vectors=0.
  - Reset mid-move or mid-door aborts immediately.
- Request latching:
  - Each edge, pend |= req for all three vectors.
  - upreq[NUM_FLOORS-1] and downreq[0] are ignored (never latch).
  - A latched bit stays set after the button releases, until served.
- Definitions:
  - here = car_pend[floor] | up_pend[floor] | down_pend[floor].
  - above = any pend bit at index > floor; below = any pend bit at index < floor.
- FSM states: IDLE, MOVE, DOOR. Outputs are decoded from registered state:
  - up = MOVE & dir_up; down = MOVE & ~dir_up; open = (state==DOOR).
- IDLE:
  - here -> DOOR, door timer = DOOR_CYCLES-1.
  - else if (dir_up & above) or (~dir_up & ~below & above) -> MOVE, dir_up=1.
  - else if below -> MOVE, dir_up=0.
  - else stay.
  - On entry to MOVE, travel timer = TRAVEL_CYCLES-1.
- MOVE:
  - Decrement the travel timer each cycle.
  - At timer==0, floor <= floor ± 1 (per dir_up), and the stop decision uses the new floor:
  - Stop (-> DOOR) if any of:
    - car_pend[new];
    - dir_up & up_pend[new];
    - ~dir_up & down_pend[new];
    - no pending requests beyond new floor in dir_up direction.
  - Otherwise reload the timer and remain in MOVE.
  - Floor never leaves 0..NUM_FLOORS-1: at floor 0 or top floor the stop condition is always true.
- DOOR:
  - open=1 for exactly DOOR_CYCLES cycles, then -> IDLE.
  - On entry to DOOR, clear car_pend[floor] and the hall bit matching dir_up.
  - If nothing is pending beyond floor in dir_up direction, also clear the opposite hall bit, and dir_up flips only if requests exist in the opposite direction.
  - During DOOR, new requests at the current floor that would be cleared on entry are not latched (clear beats set). Door timer is not restarted.
  - Requests at other floors latch normally.
- Latency:
  - Request at the car's floor while IDLE, sampled at edge E0: open high after E1, low after E1+DOOR_CYCLES.
  - Travel of N floors: up/down asserted for N*TRAVEL_CYCLES cycles.
- Simultaneous events:
  - Set and clear on the same bit in the same cycle: clear wins (current floor in DOOR only).
  - Requests above and below with dir_up=1 in IDLE: go up.
- Never assert up and down together; never assert open with up or down.

Test Plan:
- Reset then idle, no requests -> floor=0, dir_up=1, up=down=open=busy=0, all pend=0 indefinitely.
- Floor 0, carreq[3] pulsed 1 cycle (TRAVEL=4, DOOR=6) -> car_pend[3]=1; up high 12 cycles; floor steps 1,2,3 every 4 cycles; then open high 6 cycles; car_pend[3]=0; back to IDLE.
- Car moving up from floor 0 to 5, upreq[2] and downreq[2] asserted before the car reaches floor 2 -> stops at 2, up_pend[2] cleared, down_pend[2] kept; continues to 5, returns down, stops at 2, clears down_pend[2].
- Car at 4 with door open, carreq[4] pressed -> not latched, open duration unchanged (6 cycles).
- upreq[9] and downreq[0] pressed (NUM_FLOORS=10) -> no pend bit set, car stays idle; downreq[9] from floor 0 -> travels to 9, opens, dir_up flips to 0 only if a request below exists.
- resetN=1 for one cycle mid-MOVE at floor 2 with pending calls -> next cycle floor=0, up=down=0, all pend=0, state IDLE.

Source files
------------

// File: rtl/elevator_sched.sv
// Single-car LOOK elevator scheduler: latches hall/cab calls, times floor-to-floor
// travel and door dwell, and serves calls in the current sweep direction first.
module elevator_sched #(
    parameter int NUM_FLOORS    = 10,
    parameter int FLOOR_BITS    = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_FLOORS-1:0] upreq,
    input  logic [NUM_FLOORS-1:0] downreq,
    input  logic [NUM_FLOORS-1:0] carreq,
    output logic [FLOOR_BITS-1:0] floor,
    output logic                  up,
    output logic                  down,
    output logic                  open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] up_pend,
    output logic [NUM_FLOORS-1:0] down_pend,
    output logic [NUM_FLOORS-1:0] car_pend,
    output logic                  busy
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO  = {TW{1'b0}};
    localparam logic [NUM_FLOORS-1:0] UP_MASK  = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK  = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_BITS-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) begin
                r = r | v[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_BITS-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) begin
                r = r | v[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t                  state_q;
    logic [FLOOR_BITS-1:0]   floor_q;
    logic                    dir_up_q;
    logic [TW-1:0]           timer_q;
    logic [NUM_FLOORS-1:0]   up_pend_q, down_pend_q, car_pend_q;
    logic [NUM_FLOORS-1:0]   up_pend_d, down_pend_d, car_pend_d;
    logic                    clr_up_q, clr_dn_q;
    logic                    up_q, down_q, open_q, busy_q;

    logic [NUM_FLOORS-1:0]   all_pend_s, clr_vec_s;
    logic [FLOOR_BITS-1:0]   nf_s, df_s;
    logic                    above_s, below_s, go_up_s;
    logic                    beyond_s, opposite_s, ent_up_s, ent_dn_s, entry_dir_s;
    logic                    serve_s, stop_s, door_entry_s;
    logic                    clr_en_s, clr_up_s, clr_dn_s;

    // Request bookkeeping and the stop/serve decisions taken at the next edge.
    always_comb begin
        all_pend_s = up_pend_q | down_pend_q | car_pend_q;
        above_s    = any_above(all_pend_s, floor_q);
        below_s    = any_below(all_pend_s, floor_q);
        go_up_s    = above_s & (dir_up_q | ~below_s);
        if (dir_up_q) begin
            nf_s = floor_q + FLOOR_BITS'(1);
        end else begin
            nf_s = floor_q - FLOOR_BITS'(1);
        end
        // df_s is the floor at which a door would open on this edge
        if (state_q == MOVE) begin
            df_s = nf_s;
        end else begin
            df_s = floor_q;
        end
        if (dir_up_q) begin
            beyond_s   = any_above(all_pend_s, df_s);
            opposite_s = any_below(all_pend_s, df_s);
        end else begin
            beyond_s   = any_below(all_pend_s, df_s);
            opposite_s = any_above(all_pend_s, df_s);
        end
        ent_up_s    = dir_up_q | ~beyond_s;
        ent_dn_s    = ~dir_up_q | ~beyond_s;
        entry_dir_s = dir_up_q ^ (~beyond_s & opposite_s);
        // Only open the door for a call the stop would actually clear, otherwise an
        // opposite-direction hall call left at this floor would reopen it forever.
        serve_s = car_pend_q[floor_q] | (ent_up_s & up_pend_q[floor_q])
                | (ent_dn_s & down_pend_q[floor_q]);
        stop_s  = car_pend_q[nf_s] | (dir_up_q & up_pend_q[nf_s])
                | (~dir_up_q & down_pend_q[nf_s]) | ~beyond_s;
        case (state_q)
            IDLE:    door_entry_s = serve_s;
            MOVE:    door_entry_s = (timer_q == TIMER_ZERO) & stop_s;
            default: door_entry_s = 1'b0;
        endcase
        if (door_entry_s) begin
            clr_en_s = 1'b1;
            clr_up_s = ent_up_s;
            clr_dn_s = ent_dn_s;
        end else if (state_q == DOOR) begin
            clr_en_s = 1'b1;
            clr_up_s = clr_up_q;
            clr_dn_s = clr_dn_q;
        end else begin
            clr_en_s = 1'b0;
            clr_up_s = 1'b0;
            clr_dn_s = 1'b0;
        end
        clr_vec_s   = ONE_HOT0 << df_s;
        car_pend_d  = (car_pend_q | carreq) & ~(clr_vec_s & {NUM_FLOORS{clr_en_s}});
        up_pend_d   = (up_pend_q | (upreq & UP_MASK)) & ~(clr_vec_s & {NUM_FLOORS{clr_up_s}});
        down_pend_d = (down_pend_q | (downreq & DN_MASK)) & ~(clr_vec_s & {NUM_FLOORS{clr_dn_s}});
    end

    // Scheduler FSM with registered motion/door strobes.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q     <= IDLE;
            floor_q     <= {FLOOR_BITS{1'b0}};
            dir_up_q    <= 1'b1;
            timer_q     <= TIMER_ZERO;
            up_pend_q   <= {NUM_FLOORS{1'b0}};
            down_pend_q <= {NUM_FLOORS{1'b0}};
            car_pend_q  <= {NUM_FLOORS{1'b0}};
            clr_up_q    <= 1'b0;
            clr_dn_q    <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            open_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            up_pend_q   <= up_pend_d;
            down_pend_q <= down_pend_d;
            car_pend_q  <= car_pend_d;
            case (state_q)
                IDLE: begin
                    if (serve_s) begin
                        state_q  <= DOOR;
                        timer_q  <= DOOR_LOAD;
                        dir_up_q <= entry_dir_s;
                        clr_up_q <= ent_up_s;
                        clr_dn_q <= ent_dn_s;
                        open_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (go_up_s) begin
                        state_q  <= MOVE;
                        timer_q  <= TRAVEL_LOAD;
                        dir_up_q <= 1'b1;
                        up_q     <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (below_s) begin
                        state_q  <= MOVE;
                        timer_q  <= TRAVEL_LOAD;
                        dir_up_q <= 1'b0;
                        down_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                MOVE: begin
                    if (timer_q == TIMER_ZERO) begin
                        floor_q <= nf_s;
                        if (stop_s) begin
                            state_q  <= DOOR;
                            timer_q  <= DOOR_LOAD;
                            dir_up_q <= entry_dir_s;
                            clr_up_q <= ent_up_s;
                            clr_dn_q <= ent_dn_s;
                            up_q     <= 1'b0;
                            down_q   <= 1'b0;
                            open_q   <= 1'b1;
                        end else begin
                            timer_q  <= TRAVEL_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DOOR: begin
                    if (timer_q == TIMER_ZERO) begin
                        state_q <= IDLE;
                        open_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= TIMER_ZERO;
                    up_q    <= 1'b0;
                    down_q  <= 1'b0;
                    open_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign floor     = floor_q;
    assign up        = up_q;
    assign down      = down_q;
    assign open      = open_q;
    assign dir_up    = dir_up_q;
    assign busy      = busy_q;
    assign up_pend   = up_pend_q;
    assign down_pend = down_pend_q;
    assign car_pend  = car_pend_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Bench for elevator_sched: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed timings and floor/lamp expectations.
module tb_elevator_sched;

    localparam int NF = 10;
    localparam int FB = 4;
    localparam int TC = 4;
    localparam int DC = 6;
    localparam int IDLE_P = 0;
    localparam int RIDE   = 1;
    localparam int DWELL  = 2;

    logic          clk = 1'b0;
    logic          resetN;
    logic [NF-1:0] upreq, downreq, carreq;
    logic [FB-1:0] floor;
    logic          up, down, open, dir_up, busy;
    logic [NF-1:0] up_pend, down_pend, car_pend;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elevator_sched #(
        .NUM_FLOORS(NF), .FLOOR_BITS(FB), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .resetN(resetN), .upreq(upreq), .downreq(downreq), .carreq(carreq),
        .floor(floor), .up(up), .down(down), .open(open), .dir_up(dir_up),
        .up_pend(up_pend), .down_pend(down_pend), .car_pend(car_pend), .busy(busy)
    );

    // Behavioural model: call lamps as arrays, the car as floor/phase/cycles-left.
    bit m_up [NF];
    bit m_dn [NF];
    bit m_car[NF];
    int m_floor = 0;
    int m_phase = IDLE_P;
    int m_left  = 0;
    bit m_dir = 1'b1;
    bit m_kill_up = 1'b0;
    bit m_kill_dn = 1'b0;

    logic          cap_seen = 1'b0;
    logic          cap_rst;
    logic [NF-1:0] cap_up, cap_dn, cap_car;

    function automatic bit any_req(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i < NF && (m_up[i] || m_dn[i] || m_car[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ahead(int f, bit d);
        return d ? any_req(f + 1, NF - 1) : any_req(0, f - 1);
    endfunction

    task automatic model_step();
        int f, tgt;
        bit enter, was_dwell, k_up, k_dn, nd;
        if (cap_rst) begin
            for (int i = 0; i < NF; i++) begin
                m_up[i] = 1'b0; m_dn[i] = 1'b0; m_car[i] = 1'b0;
            end
            m_floor = 0; m_dir = 1'b1; m_phase = IDLE_P; m_left = 0;
            m_kill_up = 1'b0; m_kill_dn = 1'b0;
            return;
        end
        f = m_floor; tgt = f; enter = 1'b0; nd = m_dir; k_up = 1'b0; k_dn = 1'b0;
        was_dwell = (m_phase == DWELL);
        case (m_phase)
            IDLE_P: begin
                if (m_car[f] || (m_up[f] && (m_dir || !ahead(f, m_dir)))
                             || (m_dn[f] && (!m_dir || !ahead(f, m_dir)))) begin
                    enter = 1'b1;
                end else if (ahead(f, 1'b1) && (m_dir || !ahead(f, 1'b0))) begin
                    m_phase = RIDE; m_dir = 1'b1; m_left = TC;
                end else if (ahead(f, 1'b0)) begin
                    m_phase = RIDE; m_dir = 1'b0; m_left = TC;
                end
            end
            RIDE: begin
                m_left--;
                if (m_left == 0) begin
                    tgt = m_dir ? f + 1 : f - 1;
                    if (m_car[tgt] || (m_dir && m_up[tgt]) || (!m_dir && m_dn[tgt])
                        || !ahead(tgt, m_dir)) enter = 1'b1;
                    else m_left = TC;
                    m_floor = tgt;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = IDLE_P;
            end
        endcase
        if (enter) begin
            k_up = m_dir || !ahead(tgt, m_dir);
            k_dn = !m_dir || !ahead(tgt, m_dir);
            if (!ahead(tgt, m_dir) && ahead(tgt, !m_dir)) nd = !m_dir;
            m_phase = DWELL; m_left = DC; m_kill_up = k_up; m_kill_dn = k_dn;
        end
        for (int i = 0; i < NF; i++) begin
            if (cap_up[i] && i != NF - 1) m_up[i] = 1'b1;
            if (cap_dn[i] && i != 0) m_dn[i] = 1'b1;
            if (cap_car[i]) m_car[i] = 1'b1;
        end
        if (enter) begin
            m_car[tgt] = 1'b0;
            if (k_up) m_up[tgt] = 1'b0;
            if (k_dn) m_dn[tgt] = 1'b0;
            m_dir = nd;
        end else if (was_dwell) begin
            m_car[m_floor] = 1'b0;
            if (m_kill_up) m_up[m_floor] = 1'b0;
            if (m_kill_dn) m_dn[m_floor] = 1'b0;
        end
    endtask

    // Capture the inputs the DUT sees at each rising edge.
    always @(posedge clk) begin
        cap_rst  <= resetN;
        cap_up   <= upreq;
        cap_dn   <= downreq;
        cap_car  <= carreq;
        cap_seen <= 1'b1;
    end

    // Advance the model and compare every output on the falling edge.
    always @(negedge clk) begin
        logic [NF-1:0] eu, ed, ec;
        logic [FB-1:0] ef;
        logic          e_up, e_dn, e_open, e_busy;
        if (cap_seen) begin
            model_step();
            for (int i = 0; i < NF; i++) begin
                eu[i] = m_up[i]; ed[i] = m_dn[i]; ec[i] = m_car[i];
            end
            ef     = m_floor[FB-1:0];
            e_up   = (m_phase == RIDE) && m_dir;
            e_dn   = (m_phase == RIDE) && !m_dir;
            e_open = (m_phase == DWELL);
            e_busy = (m_phase != IDLE_P);
            n_cmp++;
            if ({floor, up, down, open, dir_up, busy, up_pend, down_pend, car_pend} !==
                {ef, e_up, e_dn, e_open, m_dir, e_busy, eu, ed, ec}) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL model @%0t: got fl=%0d u=%b d=%b o=%b dir=%b busy=%b upP=%b dnP=%b carP=%b expected fl=%0d u=%b d=%b o=%b dir=%b busy=%b upP=%b dnP=%b carP=%b",
                             $time, floor, up, down, open, dir_up, busy, up_pend, down_pend, car_pend,
                             ef, e_up, e_dn, e_open, m_dir, e_busy, eu, ed, ec);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b1; upreq = '0; downreq = '0; carreq = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b0;
    endtask

    task automatic go_until_open(input int budget, output int ups, output int dns);
        int n;
        n = 0; ups = 0; dns = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (up) ups++;
            if (down) dns++;
            if (open) break;
        end
        if (!open) chk("open_timeout", int'(open), 1);
    endtask

    task automatic measure_open(output int n);
        n = 0;
        while (open && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int ups, dns, n;
        resetN = 1'b1; upreq = '0; downreq = '0; carreq = '0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        // Idle after reset
        repeat (8) @(negedge clk);
        chk("idle_floor", int'(floor), 0);
        chk("idle_dir", int'(dir_up), 1);
        chk("idle_busy", int'(busy | up | down | open), 0);
        chk("idle_pend", int'(|{up_pend, down_pend, car_pend}), 0);

        // Cab call to 3 from the lobby
        carreq[3] = 1'b1; @(negedge clk); carreq = '0;
        chk("s2_latched", int'(car_pend[3]), 1);
        go_until_open(100, ups, dns);
        chk("s2_up_cycles", ups, 12);
        chk("s2_floor", int'(floor), 3);
        measure_open(n);
        chk("s2_open_cycles", n, 6);
        chk("s2_cleared", int'(car_pend[3]), 0);
        chk("s2_idle", int'(busy), 0);

        // Hall calls at 2 while heading for 5
        do_reset();
        carreq[5] = 1'b1; @(negedge clk); carreq = '0;
        @(negedge clk);
        upreq[2] = 1'b1; downreq[2] = 1'b1; @(negedge clk); upreq = '0; downreq = '0;
        go_until_open(100, ups, dns);
        chk("s3_stop2_floor", int'(floor), 2);
        chk("s3_up2_cleared", int'(up_pend[2]), 0);
        chk("s3_dn2_kept", int'(down_pend[2]), 1);
        measure_open(n);
        go_until_open(100, ups, dns);
        chk("s3_up_2to5", ups, 12);
        chk("s3_floor5", int'(floor), 5);
        chk("s3_dir_flip", int'(dir_up), 0);
        measure_open(n);
        go_until_open(100, ups, dns);
        chk("s3_dn_5to2", dns, 12);
        chk("s3_back_at2", int'(floor), 2);
        measure_open(n);
        chk("s3_all_clear", int'(|{up_pend, down_pend, car_pend}), 0);

        // Cab press at the open floor is swallowed
        do_reset();
        carreq[4] = 1'b1; @(negedge clk); carreq = '0;
        go_until_open(100, ups, dns);
        chk("s4_up_cycles", ups, 16);
        chk("s4_floor", int'(floor), 4);
        n = 0;
        carreq[4] = 1'b1;
        while (open && n < 50) begin
            n++;
            if (n == 3) carreq = '0;
            chk("s4_not_latched", int'(car_pend[4]), 0);
            @(negedge clk);
        end
        carreq = '0;
        chk("s4_open_cycles", n, 6);
        repeat (3) @(negedge clk);
        chk("s4_stays_idle", int'(busy), 0);

        // Nonexistent buttons, then a trip to the top
        do_reset();
        upreq[9] = 1'b1; downreq[0] = 1'b1;
        repeat (3) @(negedge clk);
        upreq = '0; downreq = '0;
        chk("s5_ignored", int'(|{up_pend, down_pend, car_pend}), 0);
        chk("s5_ignored_busy", int'(busy), 0);
        downreq[9] = 1'b1; @(negedge clk); downreq = '0;
        go_until_open(200, ups, dns);
        chk("s5_up_to9", ups, 36);
        chk("s5_floor9", int'(floor), 9);
        chk("s5_dir_kept", int'(dir_up), 1);
        measure_open(n);
        chk("s5_dn9_cleared", int'(down_pend[9]), 0);

        // Top with a call below flips direction
        do_reset();
        downreq[9] = 1'b1; @(negedge clk); downreq = '0;
        repeat (12) @(negedge clk);
        carreq[1] = 1'b1; @(negedge clk); carreq = '0;
        go_until_open(200, ups, dns);
        chk("s5b_floor9", int'(floor), 9);
        chk("s5b_dir_flip", int'(dir_up), 0);
        measure_open(n);
        go_until_open(200, ups, dns);
        chk("s5b_dn_9to1", dns, 32);
        chk("s5b_floor1", int'(floor), 1);
        measure_open(n);
        chk("s5b_dir_final", int'(dir_up), 0);

        // Reset in the middle of a move
        do_reset();
        carreq[7] = 1'b1; upreq[5] = 1'b1; @(negedge clk); carreq = '0; upreq = '0;
        n = 0;
        while (floor != 4'd2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reached2", int'(floor), 2);
        chk("s6_moving", int'(up), 1);
        resetN = 1'b1; @(negedge clk); resetN = 1'b0;
        chk("s6_floor", int'(floor), 0);
        chk("s6_strobes", int'(up | down | open | busy), 0);
        chk("s6_pend", int'(|{up_pend, down_pend, car_pend}), 0);
        chk("s6_dir", int'(dir_up), 1);
        repeat (5) @(negedge clk);
        chk("s6_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
